// File: rtl/fetch_queue.sv
// Fetch-to-decode decoupling FIFO holding {pc, instr, misaligned} entries.
// First-word-fall-through head, valid/ready on both sides, synchronous flush on redirect.
module fetch_queue #(
    parameter int DEPTH      = 4,
    parameter int ADDR_WIDTH = 32,
    parameter int DATA_WIDTH = 32
) (
    input  logic                         clk_i,
    input  logic                         rst_i,
    input  logic                         flush_i,
    input  logic                         valid_i,
    output logic                         ready_o,
    input  logic [ADDR_WIDTH-1:0]        pc_i,
    input  logic [DATA_WIDTH-1:0]        instr_i,
    output logic                         valid_o,
    input  logic                         ready_i,
    output logic [ADDR_WIDTH-1:0]        pc_o,
    output logic [DATA_WIDTH-1:0]        instr_o,
    output logic                         misaligned_o,
    output logic [$clog2(DEPTH+1)-1:0]   count_o
);

    localparam int PTR_W = $clog2(DEPTH);
    localparam int CNT_W = $clog2(DEPTH + 1);
    localparam logic [PTR_W-1:0] PTR_ONE = PTR_W'(1);
    localparam logic [CNT_W-1:0] CNT_ONE = CNT_W'(1);
    localparam logic [CNT_W-1:0] CNT_MAX = CNT_W'(DEPTH);

    logic [ADDR_WIDTH-1:0] r_pc_mem    [DEPTH];
    logic [DATA_WIDTH-1:0] r_instr_mem [DEPTH];
    logic                  r_mis_mem   [DEPTH];

    logic [PTR_W-1:0] r_wptr;
    logic [PTR_W-1:0] r_rptr;
    logic [CNT_W-1:0] r_count;

    logic w_ready;
    logic w_valid;
    logic w_push;
    logic w_pop;

    assign w_ready = (r_count != CNT_MAX);
    assign w_valid = (r_count != '0);
    assign w_push  = valid_i & w_ready & ~flush_i;
    assign w_pop   = w_valid & ready_i & ~flush_i;

    assign ready_o = w_ready;
    assign valid_o = w_valid;
    assign count_o = r_count;

    // Head fields are forced to zero while empty so the unreset storage never leaks out.
    assign pc_o         = w_valid ? r_pc_mem[r_rptr]    : '0;
    assign instr_o      = w_valid ? r_instr_mem[r_rptr] : '0;
    assign misaligned_o = w_valid ? r_mis_mem[r_rptr]   : 1'b0;

    always_ff @(posedge clk_i) begin
        if (w_push) begin
            r_pc_mem[r_wptr]    <= pc_i;
            r_instr_mem[r_wptr] <= instr_i;
            r_mis_mem[r_wptr]   <= (pc_i[1:0] != 2'b00);
        end
    end

    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            r_wptr  <= '0;
            r_rptr  <= '0;
            r_count <= '0;
        end else if (flush_i) begin
            r_wptr  <= '0;
            r_rptr  <= '0;
            r_count <= '0;
        end else begin
            if (w_push) r_wptr <= r_wptr + PTR_ONE;
            if (w_pop)  r_rptr <= r_rptr + PTR_ONE;
            case ({w_push, w_pop})
                2'b10:   r_count <= r_count + CNT_ONE;
                2'b01:   r_count <= r_count - CNT_ONE;
                default: r_count <= r_count;
            endcase
        end
    end

endmodule

// File: tb/tb_fetch_queue.sv
// Directed bench for fetch_queue: fill/drain, wrap, latency, flush, misalignment, async reset.
module tb_fetch_queue;

    localparam int DEPTH = 4;

    logic        clk_i = 1'b0;
    logic        rst_i;
    logic        flush_i;
    logic        valid_i;
    logic        ready_o;
    logic [31:0] pc_i;
    logic [31:0] instr_i;
    logic        valid_o;
    logic        ready_i;
    logic [31:0] pc_o;
    logic [31:0] instr_o;
    logic        misaligned_o;
    logic [2:0]  count_o;

    int n_vec = 0;
    int n_err = 0;
    int m_cnt;

    fetch_queue #(.DEPTH(DEPTH), .ADDR_WIDTH(32), .DATA_WIDTH(32)) dut (
        .clk_i(clk_i), .rst_i(rst_i), .flush_i(flush_i),
        .valid_i(valid_i), .ready_o(ready_o), .pc_i(pc_i), .instr_i(instr_i),
        .valid_o(valid_o), .ready_i(ready_i), .pc_o(pc_o), .instr_o(instr_o),
        .misaligned_o(misaligned_o), .count_o(count_o)
    );

    always #5 clk_i = ~clk_i;

    // Independent occupancy model: pushes minus pops since the last reset or flush.
    always @(posedge clk_i or posedge rst_i) begin
        if (rst_i) m_cnt <= 0;
        else if (flush_i) m_cnt <= 0;
        else m_cnt <= m_cnt + ((valid_i && m_cnt != DEPTH) ? 1 : 0)
                            - ((ready_i && m_cnt != 0) ? 1 : 0);
    end

    always @(negedge clk_i) begin
        if (!rst_i) begin
            n_vec++;
            assert (count_o <= 3'(DEPTH) && int'(count_o) == m_cnt) else begin
                n_err++;
                $error("FAIL occupancy observed=%0d expected=%0d", count_o, m_cnt);
            end
        end
    end

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        n_vec++;
        assert (obs === exp) else begin
            n_err++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk_i);
        #1;
    endtask

    task automatic drive(input logic v, input logic [31:0] pc, input logic [31:0] ins);
        valid_i = v;
        pc_i    = pc;
        instr_i = ins;
    endtask

    initial begin
        rst_i = 1'b1; flush_i = 1'b0; ready_i = 1'b0;
        drive(1'b0, '0, '0);
        #3;
        chk("rst_count", 64'(count_o), 0);
        chk("rst_valid", 64'(valid_o), 0);
        chk("rst_ready", 64'(ready_o), 1);
        chk("rst_pc", 64'(pc_o), 0);
        chk("rst_instr", 64'(instr_o), 0);
        chk("rst_mis", 64'(misaligned_o), 0);
        #9 rst_i = 1'b0;
        tick();

        // 1: fill with decoder stalled
        drive(1'b1, 32'h00, 32'hA0); tick();
        chk("t1_count1", 64'(count_o), 1);
        chk("t1_pc1", 64'(pc_o), 32'h00);
        drive(1'b1, 32'h04, 32'hA1); tick();
        drive(1'b1, 32'h08, 32'hA2); tick();
        drive(1'b1, 32'h0C, 32'hA3); tick();
        chk("t1_count4", 64'(count_o), 4);
        chk("t1_ready0", 64'(ready_o), 0);
        chk("t1_pc_hold", 64'(pc_o), 32'h00);
        chk("t1_instr_hold", 64'(instr_o), 32'hA0);

        // 2: drain from full while offering 0x10; exercises wrap
        drive(1'b1, 32'h10, 32'hA4); ready_i = 1'b1; tick();
        chk("t2_count_pop", 64'(count_o), 3);
        chk("t2_ready1", 64'(ready_o), 1);
        chk("t2_pc04", 64'(pc_o), 32'h04);
        tick();
        drive(1'b0, '0, '0);
        chk("t2_count_pp", 64'(count_o), 3);
        chk("t2_pc08", 64'(pc_o), 32'h08);
        tick();
        chk("t2_pc0C", 64'(pc_o), 32'h0C);
        tick();
        chk("t2_pc10", 64'(pc_o), 32'h10);
        chk("t2_instrA4", 64'(instr_o), 32'hA4);
        tick();
        chk("t2_empty", 64'(valid_o), 0);

        // 3: single-word latency
        drive(1'b1, 32'h20, 32'hB0);
        chk("t3_no_bypass", 64'(valid_o), 0);
        tick();
        drive(1'b0, '0, '0);
        chk("t3_valid", 64'(valid_o), 1);
        chk("t3_pc20", 64'(pc_o), 32'h20);
        tick();
        chk("t3_valid_fall", 64'(valid_o), 0);
        chk("t3_count0", 64'(count_o), 0);

        // 4: flush with both handshakes active
        ready_i = 1'b0;
        drive(1'b1, 32'h30, 32'hB1); tick();
        drive(1'b1, 32'h34, 32'hB2); tick();
        drive(1'b1, 32'h38, 32'hB3); tick();
        chk("t4_count3", 64'(count_o), 3);
        flush_i = 1'b1; ready_i = 1'b1;
        drive(1'b1, 32'h40, 32'hB4); tick();
        flush_i = 1'b0; ready_i = 1'b0;
        drive(1'b1, 32'h48, 32'hB5);
        chk("t4_count0", 64'(count_o), 0);
        chk("t4_valid0", 64'(valid_o), 0);
        tick();
        drive(1'b0, '0, '0);
        chk("t4_pc48", 64'(pc_o), 32'h48);
        chk("t4_count1", 64'(count_o), 1);
        ready_i = 1'b1; tick();
        ready_i = 1'b0;

        // 5: misaligned head followed by aligned entry
        drive(1'b1, 32'h02, 32'hC0); tick();
        drive(1'b1, 32'h44, 32'hC1); tick();
        drive(1'b0, '0, '0);
        chk("t5_pc02", 64'(pc_o), 32'h02);
        chk("t5_mis1", 64'(misaligned_o), 1);
        ready_i = 1'b1; tick();
        chk("t5_pc44", 64'(pc_o), 32'h44);
        chk("t5_mis0", 64'(misaligned_o), 0);
        tick();
        ready_i = 1'b0;
        chk("t5_empty", 64'(count_o), 0);

        // 6: asynchronous reset between edges
        drive(1'b1, 32'h50, 32'hD0); tick();
        drive(1'b1, 32'h54, 32'hD1); tick();
        drive(1'b0, '0, '0);
        chk("t6_count2", 64'(count_o), 2);
        #2 rst_i = 1'b1;
        #1;
        chk("t6_async_valid", 64'(valid_o), 0);
        chk("t6_async_count", 64'(count_o), 0);
        chk("t6_async_ready", 64'(ready_o), 1);
        #1 rst_i = 1'b0;
        drive(1'b1, 32'h58, 32'hD2); tick();
        drive(1'b0, '0, '0);
        chk("t6_resume_pc", 64'(pc_o), 32'h58);
        chk("t6_resume_count", 64'(count_o), 1);
        chk("t6_resume_instr", 64'(instr_o), 32'hD2);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
